// File: rtl/sprite_draw_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_draw_arbiter
//   Shares one sprite_draw engine among NREQ requesters. Picks a requester
//   round-robin, converts its tile coordinates to a pixel anchor, holds
//   begin_draw for GO_CYCLES, then times the draw for DRAW_CYCLES because the
//   engine has no completion output.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   req[NREQ]           level request per requester
//   req_col[5*NREQ]     tile column of requester i in [5i+4:5i], valid 0..19
//   req_row[4*NREQ]     tile row of requester i in [4i+3:4i], valid 0..14
//   req_sprite[3*NREQ]  sprite id of requester i in [3i+2:3i]
//   ack[NREQ]           one-cycle pulse: request i accepted (drawn or dropped)
//   err                 one-cycle pulse with ack: request out of range, dropped
//   done[NREQ]          one-cycle pulse: draw for requester i finished
//   busy                accept edge .. edge after done pulse
//   draw_x/y/sprite     registered pixel anchor and sprite id for the engine
//   begin_draw          go strobe to the engine
// ---------------------------------------------------------------------------
module sprite_draw_arbiter #(
   parameter int NREQ        = 3,
   parameter int GO_CYCLES   = 2,
   parameter int DRAW_CYCLES = 66
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [5*NREQ-1:0] req_col,
   input  logic [4*NREQ-1:0] req_row,
   input  logic [3*NREQ-1:0] req_sprite,
   output logic [NREQ-1:0]   ack,
   output logic              err,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [7:0]        draw_x,
   output logic [6:0]        draw_y,
   output logic [2:0]        draw_sprite,
   output logic              begin_draw
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX = (GO_CYCLES > DRAW_CYCLES) ? GO_CYCLES : DRAW_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, GO, DRAW, DONE} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   last, last_nx;   // last requester acknowledged
   logic [IW-1:0]   cur, cur_nx;     // requester whose draw is in flight
   logic [CW-1:0]   cnt, cnt_nx;

   logic [NREQ-1:0] ack_nx, done_nx;
   logic            err_nx, busy_nx, bd_nx;
   logic [7:0]      x_nx;
   logic [6:0]      y_nx;
   logic [2:0]      spr_nx;

   // Round-robin pick: first set bit after the last winner, wrapping.
   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [4:0]      win_col;
   logic [3:0]      win_row;
   logic [2:0]      win_spr;
   logic            win_valid;

   always_comb begin : pick
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = last;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   assign win_col   = req_col[5*win_idx +: 5];
   assign win_row   = req_row[4*win_idx +: 4];
   assign win_spr   = req_sprite[3*win_idx +: 3];
   assign win_valid = (win_col <= 5'd19) && (win_row <= 4'd14);

   always_comb begin
      state_nx = state;
      last_nx  = last;
      cur_nx   = cur;
      cnt_nx   = cnt;
      ack_nx   = '0;
      err_nx   = 1'b0;
      done_nx  = '0;
      busy_nx  = busy;
      bd_nx    = begin_draw;
      x_nx     = draw_x;
      y_nx     = draw_y;
      spr_nx   = draw_sprite;
      case (state)
         IDLE: begin
            if (win_found) begin
               ack_nx[win_idx] = 1'b1;
               last_nx         = win_idx;
               if (win_valid) begin
                  cur_nx   = win_idx;
                  x_nx     = {win_col, 3'b000};
                  y_nx     = {win_row, 3'b000};
                  spr_nx   = win_spr;
                  bd_nx    = 1'b1;
                  busy_nx  = 1'b1;
                  cnt_nx   = '0;
                  state_nx = GO;
               end else begin
                  // rejected: draw_* and begin_draw keep their old values
                  err_nx = 1'b1;
               end
            end
         end
         GO: begin
            // begin_draw was raised on the accept edge, so it has been high
            // cnt+1 cycles here.
            if (cnt == CW'(GO_CYCLES - 1)) begin
               bd_nx    = 1'b0;
               cnt_nx   = '0;
               state_nx = DRAW;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DRAW: begin
            if (cnt == CW'(DRAW_CYCLES - 1)) begin
               done_nx[cur] = 1'b1;
               state_nx     = DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= IW'(NREQ - 1);
         cur         <= '0;
         cnt         <= '0;
         ack         <= '0;
         err         <= 1'b0;
         done        <= '0;
         busy        <= 1'b0;
         begin_draw  <= 1'b0;
         draw_x      <= '0;
         draw_y      <= '0;
         draw_sprite <= '0;
      end else begin
         state       <= state_nx;
         last        <= last_nx;
         cur         <= cur_nx;
         cnt         <= cnt_nx;
         ack         <= ack_nx;
         err         <= err_nx;
         done        <= done_nx;
         busy        <= busy_nx;
         begin_draw  <= bd_nx;
         draw_x      <= x_nx;
         draw_y      <= y_nx;
         draw_sprite <= spr_nx;
      end
   end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_arbiter
//   Directed scenarios (reset, single draw, contention, out-of-range,
//   boundary, busy immunity) followed by randomized requester traffic.
//   A timestamp-based reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_sprite_draw_arbiter;
   localparam int NREQ = 3;
   localparam int GO   = 2;
   localparam int DRW  = 66;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [5*NREQ-1:0] req_col = '0;
   logic [4*NREQ-1:0] req_row = '0;
   logic [3*NREQ-1:0] req_sprite = '0;
   logic [NREQ-1:0]   ack, done;
   logic              err, busy, begin_draw;
   logic [7:0]        draw_x;
   logic [6:0]        draw_y;
   logic [2:0]        draw_sprite;

   always #5 clk = ~clk;

   sprite_draw_arbiter #(.NREQ(NREQ), .GO_CYCLES(GO), .DRAW_CYCLES(DRW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_col(req_col), .req_row(req_row),
      .req_sprite(req_sprite), .ack(ack), .err(err), .done(done), .busy(busy),
      .draw_x(draw_x), .draw_y(draw_y), .draw_sprite(draw_sprite),
      .begin_draw(begin_draw)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A draw accepted at cycle A: begin_draw high for cycles A..A+GO-1,
   // done pulse at A+GO+DRW, busy clears at A+GO+DRW+1, next pick at +2.
   logic [NREQ-1:0] e_ack, e_done;
   logic            e_err, e_busy, e_bd;
   logic [7:0]      e_x;
   logic [6:0]      e_y;
   logic [2:0]      e_spr;
   int              m_last, m_w, m_acc, m_n;
   bit              m_active;

   function automatic int pick(input logic [NREQ-1:0] r, input int last);
      int w;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
         if (w < 0 && r[(last + k) % NREQ]) w = (last + k) % NREQ;
      return w;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int col_of(input int i);
      return int'(req_col[5*i +: 5]);
   endfunction
   function automatic int row_of(input int i);
      return int'(req_row[4*i +: 4]);
   endfunction
   function automatic int spr_of(input int i);
      return int'(req_sprite[3*i +: 3]);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         e_ack <= '0; e_done <= '0; e_err <= 1'b0; e_busy <= 1'b0; e_bd <= 1'b0;
         e_x <= '0; e_y <= '0; e_spr <= '0;
         m_last <= NREQ - 1; m_w <= 0; m_acc <= 0; m_n <= 0; m_active <= 1'b0;
      end else begin
         m_n    <= m_n + 1;
         e_ack  <= '0;
         e_err  <= 1'b0;
         e_done <= '0;
         if (m_active) begin
            if (m_n + 1 == m_acc + GO) e_bd <= 1'b0;
            if (m_n + 1 == m_acc + GO + DRW) e_done <= onehot(m_w);
            if (m_n + 1 == m_acc + GO + DRW + 1) begin
               e_busy   <= 1'b0;
               m_active <= 1'b0;
            end
         end else if (req != '0) begin
            e_ack  <= onehot(pick(req, m_last));
            m_last <= pick(req, m_last);
            if (col_of(pick(req, m_last)) <= 19 && row_of(pick(req, m_last)) <= 14) begin
               m_w      <= pick(req, m_last);
               m_acc    <= m_n + 1;
               m_active <= 1'b1;
               e_bd     <= 1'b1;
               e_busy   <= 1'b1;
               e_x      <= 8'(col_of(pick(req, m_last)) * 8);
               e_y      <= 7'(row_of(pick(req, m_last)) * 8);
               e_spr    <= 3'(spr_of(pick(req, m_last)));
            end else begin
               e_err <= 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int i, input int c, input int r, input int s);
      req_col[5*i +: 5]    = c[4:0];
      req_row[4*i +: 4]    = r[3:0];
      req_sprite[3*i +: 3] = s[2:0];
      req[i]               = 1'b1;
   endtask

   // Advance to the next negedge, compare everything, then drop any request
   // acknowledged on the previous edge.
   task automatic cycle();
      @(negedge clk);
      chk("ack", ack, e_ack);
      chk("err", err, e_err);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("begin_draw", begin_draw, e_bd);
      chk("draw_x", draw_x, e_x);
      chk("draw_y", draw_y, e_y);
      chk("draw_sprite", draw_sprite, e_spr);
      for (int i = 0; i < NREQ; i++) if (e_ack[i]) req[i] = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && e_busy; c++) cycle();
      cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   logic [NREQ-1:0] order[$];
   logic [NREQ-1:0] want_order[4];
   int lat, bdcnt;
   bit saw_done;

   initial begin
      want_order[0] = 3'b001; want_order[1] = 3'b010;
      want_order[2] = 3'b100; want_order[3] = 3'b001;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bd", begin_draw, 0);
      chk("rst_x", draw_x, 0);
      reset = 1'b0;

      // T3 contention: all three requesting, re-raise after own done
      for (int i = 0; i < NREQ; i++) set_req(i, 2 + i, 1 + i, i);
      for (int c = 0; c < 400 && order.size() < 4; c++) begin
         cycle();
         if (ack != '0) begin
            order.push_back(ack);
            chk("t3_onehot", $countones(ack), 1);
         end
         for (int i = 0; i < NREQ; i++) if (e_done[i]) req[i] = 1'b1;
      end
      req = '0;
      chk("t3_nacks", order.size(), 4);
      for (int k = 0; k < order.size() && k < 4; k++) chk("t3_order", order[k], want_order[k]);
      drain();

      // T2 single draw
      set_req(0, 3, 2, 5);
      cycle();
      chk("t2_ack", ack, 3'b001);
      chk("t2_x", draw_x, 24);
      chk("t2_y", draw_y, 16);
      chk("t2_spr", draw_sprite, 5);
      lat = 0;
      bdcnt = int'(begin_draw);
      for (int c = 0; c < 200; c++) begin
         cycle();
         lat++;
         bdcnt += int'(begin_draw);
         if (done != '0) break;
      end
      chk("t2_lat", lat, GO + DRW);
      chk("t2_go", bdcnt, GO);
      chk("t2_done", done, 3'b001);
      cycle();
      chk("t2_busy_off", busy, 0);
      cycle();

      // T4 out of range, next requester served right after
      set_req(1, 20, 0, 3);
      set_req(2, 4, 5, 6);
      cycle();
      chk("t4_ack", ack, 3'b010);
      chk("t4_err", err, 1);
      chk("t4_bd", begin_draw, 0);
      chk("t4_busy", busy, 0);
      chk("t4_x_hold", draw_x, 24);
      cycle();
      chk("t4_next", ack, 3'b100);
      chk("t4_err_off", err, 0);
      drain();

      // T5 boundary
      set_req(0, 19, 14, 7);
      cycle();
      chk("t5_ack", ack, 3'b001);
      chk("t5_err", err, 0);
      chk("t5_x", draw_x, 152);
      chk("t5_y", draw_y, 112);
      chk("t5_spr", draw_sprite, 7);
      drain();

      // T6 busy immunity
      set_req(0, 1, 1, 1);
      cycle();
      repeat (10) cycle();
      req_col[5 +: 5] = 5'd7;
      req_row[4 +: 4] = 4'd3;
      set_req(2, 5, 5, 2);
      saw_done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         cycle();
         if (!saw_done) chk("t6_x_stable", draw_x, 8);
         if (done != '0) saw_done = 1'b1;
         if (ack[2]) break;
      end
      chk("t6_after_done", saw_done, 1);
      chk("t6_ack2", ack, 3'b100);
      drain();

      // T1 mid-draw asynchronous reset
      set_req(0, 6, 6, 1);
      cycle();
      repeat (20) cycle();
      #2 reset = 1'b1;
      #1;
      chk("t1_busy", busy, 0);
      chk("t1_bd", begin_draw, 0);
      chk("t1_x", draw_x, 0);
      chk("t1_spr", draw_sprite, 0);
      set_req(0, 2, 2, 2);
      @(negedge clk);
      reset = 1'b0;
      cycle();
      chk("t1_ack", ack, 3'b001);
      drain();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && !e_ack[i]) begin
               req_col[5*i +: 5]    = 5'($urandom_range(0, 21));
               req_row[4*i +: 4]    = 4'($urandom_range(0, 15));
               req_sprite[3*i +: 3] = 3'($urandom_range(0, 7));
               if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
